dcdl_code_ctrl: RTL and testbench
=================================

// Module: dcdl_code_ctrl
// PURPOSE
//  Parametrised delay-code controller for the coarse/fine DCDL chain of the DLL.
//  Holds a linear delay code and drives the coarse and fine thermometer pairs (T/Tb, T_f/Tb_f).
//  The code changes by at most one LSB per step, with a settle gap after each step, so the line never sees multi-stage jumps.
//  Modes: direct load of a target code (slew to it), or up/dn tracking from the phase detector with lock detect.
// PARAMETERS
//  COARSE_N  16  coarse stages; coarse thermometer width
//  FINE_N    8   fine steps per coarse step; fine thermometer width
//  CODE_W    $clog2(COARSE_N*FINE_N+1)  code width
//  SETTLE    3   idle cycles after each applied step (>=1)
//  LOCK_CNT  4   consecutive up/dn direction reversals needed to declare lock
//  RST_CODE  0   code loaded on reset (<= CODE_MAX)
// PORTS
//  clk        in   1        controller clock (DLL reference domain)
//  rst_n      in   1        synchronous reset, active low
//  mode       in   1        0 = target slew, 1 = phase-detector tracking
//  freeze     in   1        1 = take no step; FSM and counters hold
//  tgt_vld    in   1        target request (mode 0)
//  tgt_code   in   CODE_W   target code, saturated to CODE_MAX on capture
//  tgt_ack    out  1        1-cycle pulse when code == captured target
//  pd_up      in   1        increase-delay request (mode 1)
//  pd_dn      in   1        decrease-delay request (mode 1)
//  code       out  CODE_W   current code = coarse_cnt*FINE_N + fine_cnt
//  T, Tb      out  COARSE_N coarse thermometer / complement
//  T_f, Tb_f  out  FINE_N   fine thermometer / complement
//  busy       out  1        1 in SLEW or HOLD
//  locked     out  1        tracking lock flag
//  at_min     out  1        code == 0
//  at_max     out  1        code == CODE_MAX
// BEHAVIOUR
//  CODE_MAX = COARSE_N*FINE_N. State is coarse_cnt 0..COARSE_N and fine_cnt 0..FINE_N-1.
//  At CODE_MAX: coarse_cnt=COARSE_N and fine_cnt=0.
//  T[i] = (i < coarse_cnt). T_f[i] = (i < fine_cnt). Tb = ~T and Tb_f = ~T_f at all times.
//  All outputs are registered. Reset: code=RST_CODE, T/T_f decoded from RST_CODE, busy=0, locked=0, tgt_ack=0, lock count=0, state IDLE.
//  Step +1: fine_cnt++. If fine_cnt was FINE_N-1: fine_cnt=0 and coarse_cnt++ in the same cycle.
//  Step -1: mirror of step +1; borrow sets fine_cnt=FINE_N-1.
//  Steps never go past 0 or CODE_MAX. A request to step past a limit is dropped, with no wrap.
//  FSM:
//   IDLE: mode 0 with tgt_vld=1: capture the saturated target.
//     If target == code: tgt_ack=1 next cycle and stay in IDLE. Else go to SLEW.
//     mode 1: evaluate pd_up/pd_dn (next line).
//   IDLE, mode 1: pd_up^pd_dn and not at the limit: apply the step and go to HOLD.
//     Both or neither asserted: no step.
//   SLEW: one step toward the target this cycle, then go to HOLD.
//   HOLD: count SETTLE cycles, then:
//     mode 0 and code != target: go to SLEW.
//     mode 0 and code == target: tgt_ack pulse and go to IDLE.
//     mode 1: go to IDLE.
//  Timing: one step per SETTLE+1 cycles. Slewing a distance d takes d*(SETTLE+1) cycles.
//  freeze=1: no step is applied, the HOLD counter and FSM hold, and captured target/lock state are kept.
//  tgt_vld outside IDLE is ignored; no queueing.
//  A mode change while busy takes effect when the FSM next returns to IDLE.
//  Lock, mode 1 only:
//   Each applied step opposite in direction to the previous step increments the lock count.
//   A same-direction step clears it.
//   locked=1 once the count reaches LOCK_CNT. locked clears on a same-direction step.
//   Entering mode 0 clears the count and locked.
//  rst_n=0 mid-slew: reset values on the next edge; the captured target is discarded.
// TESTING
//  1. Reset, RST_CODE=0 -> code=0, T=16'h0000, Tb=16'hFFFF, T_f=8'h00, at_min=1, busy=0.
//  2. Mode 0, tgt_code=9 -> code steps 1..9, one step every 4 cycles.
//     At code 8: T=16'h0001, T_f=8'h00. At code 9: T_f=8'h01. tgt_ack one pulse after 36 cycles.
//  3. Mode 0 from code 8, tgt_code=7 -> T=16'h0000, T_f=8'h7F.
//     Mode 0, tgt_code=200 -> saturates at 128: T=16'hFFFF, at_max=1, tgt_ack pulse.
//  4. freeze=1 for 10 cycles mid-slew -> code constant. After release, slew resumes and ends with one ack.
//  5. Mode 1, pd_up/pd_dn alternating -> locked=1 after the 4th reversal.
//     Two consecutive pd_up -> locked=0. pd_up=pd_dn=1 -> no step.
//  6. rst_n=0 for one cycle mid-slew -> outputs equal reset values. Then tgt_vld=0 -> code stays RST_CODE.

Source files
------------

// File: rtl/dcdl_code_if.sv
// dcdl_code_if
//   Bundles the control, target-handshake, phase-detector and code/thermometer
//   signals of the DCDL delay-code controller.
//   master : drives mode, freeze, tgt_vld, tgt_code, pd_up, pd_dn and observes the rest
//   slave  : the controller itself, driving tgt_ack, code, T/Tb, T_f/Tb_f, busy,
//            locked, at_min and at_max
interface dcdl_code_if #(
  parameter int COARSE_N = 16,
  parameter int FINE_N   = 8,
  parameter int CODE_W   = $clog2(COARSE_N*FINE_N+1)
);
  logic                mode;
  logic                freeze;
  logic                tgt_vld;
  logic [CODE_W-1:0]   tgt_code;
  logic                tgt_ack;
  logic                pd_up;
  logic                pd_dn;
  logic [CODE_W-1:0]   code;
  logic [COARSE_N-1:0] T;
  logic [COARSE_N-1:0] Tb;
  logic [FINE_N-1:0]   T_f;
  logic [FINE_N-1:0]   Tb_f;
  logic                busy;
  logic                locked;
  logic                at_min;
  logic                at_max;

  modport master (
    output mode, freeze, tgt_vld, tgt_code, pd_up, pd_dn,
    input  tgt_ack, code, T, Tb, T_f, Tb_f, busy, locked, at_min, at_max
  );

  modport slave (
    input  mode, freeze, tgt_vld, tgt_code, pd_up, pd_dn,
    output tgt_ack, code, T, Tb, T_f, Tb_f, busy, locked, at_min, at_max
  );
endinterface

// File: rtl/dcdl_code_ctrl.sv
// dcdl_code_ctrl
//   Delay-code controller for the coarse/fine DCDL chain of the DLL. Holds a
//   linear code (coarse_cnt*FINE_N + fine_cnt) and moves it by at most one LSB
//   per step, leaving SETTLE idle cycles after every step. Mode 0 slews toward
//   a captured target and acknowledges arrival; mode 1 follows the phase
//   detector and flags lock after LOCK_CNT direction reversals.
//   Ports:
//     clk   - controller clock
//     rst_n - synchronous reset, active low
//     bus   - dcdl_code_if slave: mode/freeze, tgt_vld/tgt_code/tgt_ack,
//             pd_up/pd_dn, code, T/Tb, T_f/Tb_f, busy, locked, at_min/at_max
module dcdl_code_ctrl #(
  parameter int COARSE_N = 16,
  parameter int FINE_N   = 8,
  parameter int CODE_W   = $clog2(COARSE_N*FINE_N+1),
  parameter int SETTLE   = 3,
  parameter int LOCK_CNT = 4,
  parameter int RST_CODE = 0
) (
  input logic        clk,
  input logic        rst_n,
  dcdl_code_if.slave bus
);

  localparam int CODE_MAX = COARSE_N * FINE_N;
  localparam int CW = $clog2(COARSE_N + 1);
  localparam int FW = (FINE_N > 1) ? $clog2(FINE_N) : 1;
  localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);

  localparam logic [CODE_W-1:0] CODE_MAX_V = CODE_W'(CODE_MAX);
  localparam logic [CODE_W-1:0] RST_CODE_V = CODE_W'(RST_CODE);
  localparam logic [CW-1:0]     RST_COARSE = CW'(RST_CODE / FINE_N);
  localparam logic [FW-1:0]     RST_FINE   = FW'(RST_CODE % FINE_N);
  localparam logic [FW-1:0]     FINE_TOP   = FW'(FINE_N - 1);
  localparam logic [HW-1:0]     HOLD_LAST  = HW'(SETTLE - 1);
  localparam logic [LW-1:0]     LOCK_V     = LW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, SLEW, HOLD} state_t;

  state_t              state;
  logic [HW-1:0]       hold_cnt;
  logic [CODE_W-1:0]   target;
  logic                cur_mode;
  logic [CW-1:0]       coarse_cnt;
  logic [FW-1:0]       fine_cnt;
  logic [CODE_W-1:0]   code_q;
  logic [COARSE_N-1:0] t_q;
  logic [COARSE_N-1:0] tb_q;
  logic [FINE_N-1:0]   tf_q;
  logic [FINE_N-1:0]   tbf_q;
  logic                busy_q;
  logic                locked_q;
  logic                ack_q;
  logic                at_min_q;
  logic                at_max_q;
  logic [LW-1:0]       lock_cnt;
  logic                last_up;
  logic                have_last;

  logic                dir_up;
  logic                limit_hit;
  logic                do_step;
  logic [CW-1:0]       nxt_coarse;
  logic [FW-1:0]       nxt_fine;
  logic [CODE_W-1:0]   nxt_code;
  logic [CODE_W-1:0]   tgt_sat;

  function automatic logic [COARSE_N-1:0] therm_c(input logic [CW-1:0] n);
    logic [COARSE_N-1:0] t;
    for (int i = 0; i < COARSE_N; i++) t[i] = (i < int'(n));
    return t;
  endfunction

  function automatic logic [FINE_N-1:0] therm_f(input logic [FW-1:0] n);
    logic [FINE_N-1:0] t;
    for (int i = 0; i < FINE_N; i++) t[i] = (i < int'(n));
    return t;
  endfunction

  // Step direction and the counter values one step away in that direction.
  // In SLEW the direction comes from the target, otherwise from pd_up; the
  // limit check uses the registered at_min/at_max flags so a step past
  // either end is simply dropped.
  always_comb begin
    dir_up     = (state == SLEW) ? (target > code_q) : bus.pd_up;
    nxt_coarse = coarse_cnt;
    nxt_fine   = fine_cnt;
    nxt_code   = code_q;
    if (dir_up) begin
      nxt_code = code_q + CODE_W'(1);
      if (fine_cnt == FINE_TOP) begin
        nxt_fine   = '0;
        nxt_coarse = coarse_cnt + CW'(1);
      end else begin
        nxt_fine = fine_cnt + FW'(1);
      end
    end else begin
      nxt_code = code_q - CODE_W'(1);
      if (fine_cnt == '0) begin
        nxt_fine   = FINE_TOP;
        nxt_coarse = coarse_cnt - CW'(1);
      end else begin
        nxt_fine = fine_cnt - FW'(1);
      end
    end
    limit_hit = dir_up ? at_max_q : at_min_q;
    tgt_sat   = (bus.tgt_code > CODE_MAX_V) ? CODE_MAX_V : bus.tgt_code;
    do_step   = !bus.freeze && !limit_hit &&
                ((state == SLEW) ||
                 ((state == IDLE) && bus.mode && (bus.pd_up ^ bus.pd_dn)));
  end

  // Controller FSM plus the registered code and thermometer outputs. freeze
  // blocks every state update; only the one-cycle ack is still cleared. The
  // mode is latched on leaving IDLE so a mid-flight mode change waits until
  // the FSM comes back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      target     <= RST_CODE_V;
      cur_mode   <= 1'b0;
      coarse_cnt <= RST_COARSE;
      fine_cnt   <= RST_FINE;
      code_q     <= RST_CODE_V;
      t_q        <= therm_c(RST_COARSE);
      tb_q       <= ~therm_c(RST_COARSE);
      tf_q       <= therm_f(RST_FINE);
      tbf_q      <= ~therm_f(RST_FINE);
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      ack_q      <= 1'b0;
      at_min_q   <= (RST_CODE_V == '0);
      at_max_q   <= (RST_CODE_V == CODE_MAX_V);
      lock_cnt   <= '0;
      last_up    <= 1'b0;
      have_last  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (do_step) begin
        coarse_cnt <= nxt_coarse;
        fine_cnt   <= nxt_fine;
        code_q     <= nxt_code;
        t_q        <= therm_c(nxt_coarse);
        tb_q       <= ~therm_c(nxt_coarse);
        tf_q       <= therm_f(nxt_fine);
        tbf_q      <= ~therm_f(nxt_fine);
        at_min_q   <= (nxt_code == '0);
        at_max_q   <= (nxt_code == CODE_MAX_V);
      end
      if (!bus.freeze) begin
        case (state)
          IDLE: begin
            cur_mode <= bus.mode;
            if (!bus.mode) begin
              lock_cnt  <= '0;
              locked_q  <= 1'b0;
              have_last <= 1'b0;
              if (bus.tgt_vld) begin
                target <= tgt_sat;
                if (tgt_sat == code_q) begin
                  ack_q <= 1'b1;
                end else begin
                  state  <= SLEW;
                  busy_q <= 1'b1;
                end
              end
            end else if (do_step) begin
              state     <= HOLD;
              busy_q    <= 1'b1;
              hold_cnt  <= '0;
              have_last <= 1'b1;
              last_up   <= bus.pd_up;
              // The first step after entering tracking has no predecessor,
              // so it neither counts as a reversal nor clears the count.
              if (have_last && (last_up != bus.pd_up)) begin
                if (lock_cnt < LOCK_V) lock_cnt <= lock_cnt + LW'(1);
                if (lock_cnt >= LOCK_V - LW'(1)) locked_q <= 1'b1;
              end else if (have_last) begin
                lock_cnt <= '0;
                locked_q <= 1'b0;
              end
            end
          end
          SLEW: begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (!cur_mode && (code_q != target)) begin
                state <= SLEW;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
                if (!cur_mode) ack_q <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tgt_ack = ack_q;
  assign bus.code    = code_q;
  assign bus.T       = t_q;
  assign bus.Tb      = tb_q;
  assign bus.T_f     = tf_q;
  assign bus.Tb_f    = tbf_q;
  assign bus.busy    = busy_q;
  assign bus.locked  = locked_q;
  assign bus.at_min  = at_min_q;
  assign bus.at_max  = at_max_q;

endmodule

// File: tb/tb_dcdl_code_ctrl.sv
// tb_dcdl_code_ctrl
//   Directed bench for dcdl_code_ctrl with default parameters (16 coarse, 8
//   fine, SETTLE 3, LOCK_CNT 4, RST_CODE 0). Inputs change and outputs are
//   sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_dcdl_code_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dcdl_code_if bus ();

  dcdl_code_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Request a target in mode 0 and wait (bounded) for its acknowledge.
  task automatic applyStimulus(input logic [7:0] tgt, input int budget,
                               input string tag);
    logic got;
    bus.tgt_vld  = 1'b1;
    bus.tgt_code = tgt;
    cycle(1);
    bus.tgt_vld = 1'b0;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (bus.tgt_ack) got = 1'b1;
      else cycle(1);
    end
    checkOutput(tag, {31'd0, got}, 32'd1);
  endtask

  // One phase-detector request followed by the settle gap.
  task automatic pdStep(input logic up, input logic dn);
    bus.pd_up = up;
    bus.pd_dn = dn;
    cycle(1);
    bus.pd_up = 1'b0;
    bus.pd_dn = 1'b0;
    cycle(3);
  endtask

  initial begin
    int acks;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.mode = 1'b0;
    bus.freeze = 1'b0;
    bus.tgt_vld = 1'b0;
    bus.tgt_code = '0;
    bus.pd_up = 1'b0;
    bus.pd_dn = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_code",  32'(bus.code),   32'd0);
    checkOutput("rst_T",     32'(bus.T),      32'h0000);
    checkOutput("rst_Tb",    32'(bus.Tb),     32'hFFFF);
    checkOutput("rst_Tf",    32'(bus.T_f),    32'h00);
    checkOutput("rst_Tbf",   32'(bus.Tb_f),   32'hFF);
    checkOutput("rst_atmin", 32'(bus.at_min), 32'd1);
    checkOutput("rst_atmax", 32'(bus.at_max), 32'd0);
    checkOutput("rst_busy",  32'(bus.busy),   32'd0);
    checkOutput("rst_lock",  32'(bus.locked), 32'd0);
    checkOutput("rst_ack",   32'(bus.tgt_ack),32'd0);

    // Slew 0 -> 9: step k lands on edge 4k-3, ack on edge 36
    rst_n = 1'b1;
    bus.tgt_vld  = 1'b1;
    bus.tgt_code = 8'd9;
    cycle(1);
    bus.tgt_vld = 1'b0;
    checkOutput("slew_busy0", 32'(bus.busy), 32'd1);
    for (int n = 1; n <= 40; n++) begin
      cycle(1);
      checkOutput($sformatf("slew_code_%0d", n), 32'(bus.code),
                  32'((((n + 3) / 4) > 9) ? 9 : ((n + 3) / 4)));
      checkOutput($sformatf("slew_ack_%0d", n), 32'(bus.tgt_ack),
                  32'(n == 36));
      if (n == 29) begin
        checkOutput("code8_T",  32'(bus.T),   32'h0001);
        checkOutput("code8_Tf", 32'(bus.T_f), 32'h00);
      end
      if (n == 33) begin
        checkOutput("code9_T",  32'(bus.T),   32'h0001);
        checkOutput("code9_Tf", 32'(bus.T_f), 32'h01);
      end
    end

    // Borrow across the coarse boundary and saturation at CODE_MAX
    applyStimulus(8'd8, 20, "ack_to8");
    applyStimulus(8'd7, 20, "ack_to7");
    checkOutput("code7",    32'(bus.code), 32'd7);
    checkOutput("code7_T",  32'(bus.T),    32'h0000);
    checkOutput("code7_Tf", 32'(bus.T_f),  32'h7F);
    checkOutput("code7_Tbf",32'(bus.Tb_f), 32'h80);
    applyStimulus(8'd200, 600, "ack_sat");
    checkOutput("sat_code",  32'(bus.code),   32'd128);
    checkOutput("sat_T",     32'(bus.T),      32'hFFFF);
    checkOutput("sat_Tb",    32'(bus.Tb),     32'h0000);
    checkOutput("sat_Tf",    32'(bus.T_f),    32'h00);
    checkOutput("sat_atmax", 32'(bus.at_max), 32'd1);
    checkOutput("sat_atmin", 32'(bus.at_min), 32'd0);

    // Target equal to the current code: immediate ack, no slew
    cycle(1);
    bus.tgt_vld  = 1'b1;
    bus.tgt_code = 8'd128;
    cycle(1);
    bus.tgt_vld = 1'b0;
    checkOutput("eq_ack",  32'(bus.tgt_ack), 32'd1);
    checkOutput("eq_busy", 32'(bus.busy),    32'd0);
    cycle(1);
    checkOutput("eq_ack_pulse", 32'(bus.tgt_ack), 32'd0);

    // Freeze mid-slew 128 -> 100: after 10 edges three steps are done (125)
    bus.tgt_vld  = 1'b1;
    bus.tgt_code = 8'd100;
    cycle(1);
    bus.tgt_vld = 1'b0;
    cycle(10);
    checkOutput("frz_pre", 32'(bus.code), 32'd125);
    bus.freeze = 1'b1;
    cycle(10);
    checkOutput("frz_code", 32'(bus.code), 32'd125);
    checkOutput("frz_busy", 32'(bus.busy), 32'd1);
    bus.freeze = 1'b0;
    acks = 0;
    for (int i = 0; i < 150; i++) begin
      cycle(1);
      if (bus.tgt_ack) acks++;
    end
    checkOutput("frz_acks", 32'(acks),      32'd1);
    checkOutput("frz_end",  32'(bus.code),  32'd100);

    // Tracking: four reversals give lock, a same-direction step drops it
    bus.mode = 1'b1;
    pdStep(1'b1, 1'b0);
    checkOutput("pd_up1", 32'(bus.code), 32'd101);
    pdStep(1'b0, 1'b1);
    pdStep(1'b1, 1'b0);
    pdStep(1'b0, 1'b1);
    checkOutput("pd_rev3_lock", 32'(bus.locked), 32'd0);
    checkOutput("pd_rev3_code", 32'(bus.code),   32'd100);
    pdStep(1'b1, 1'b0);
    checkOutput("pd_rev4_lock", 32'(bus.locked), 32'd1);
    checkOutput("pd_rev4_code", 32'(bus.code),   32'd101);
    pdStep(1'b1, 1'b0);
    checkOutput("pd_same_lock", 32'(bus.locked), 32'd0);
    checkOutput("pd_same_code", 32'(bus.code),   32'd102);
    bus.pd_up = 1'b1;
    bus.pd_dn = 1'b1;
    cycle(1);
    checkOutput("pd_both_code", 32'(bus.code), 32'd102);
    checkOutput("pd_both_busy", 32'(bus.busy), 32'd0);
    bus.pd_up = 1'b0;
    bus.pd_dn = 1'b0;

    // Reset mid-slew discards the target
    bus.mode = 1'b0;
    bus.tgt_vld  = 1'b1;
    bus.tgt_code = 8'd110;
    cycle(1);
    bus.tgt_vld = 1'b0;
    cycle(5);
    rst_n = 1'b0;
    cycle(1);
    checkOutput("mrst_code",  32'(bus.code),   32'd0);
    checkOutput("mrst_T",     32'(bus.T),      32'h0000);
    checkOutput("mrst_Tb",    32'(bus.Tb),     32'hFFFF);
    checkOutput("mrst_Tf",    32'(bus.T_f),    32'h00);
    checkOutput("mrst_busy",  32'(bus.busy),   32'd0);
    checkOutput("mrst_atmin", 32'(bus.at_min), 32'd1);
    checkOutput("mrst_lock",  32'(bus.locked), 32'd0);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1);
      if (bus.tgt_ack) acks++;
    end
    checkOutput("post_code", 32'(bus.code), 32'd0);
    checkOutput("post_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_acks", 32'(acks),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
